integral_window_deserializer: RTL
=================================

# integral_window_deserializer

- Reader for the integral-image window FIFO.
- Waits until a full window of `WIN_WIDTH*WIN_HEIGHT` integral values is buffered, then drains it with a back-to-back read burst.
- Reassembles the values into a parallel window and presents it to the classifier stage with a valid/ready handshake.
- Sits between the integral-image FIFO (single clock, 1-cycle read latency, non-show-ahead) and the Haar feature evaluation logic.

## Interface
- `DATA_WIDTH`, 8: bit width of one integral value.
- `ADDR_WIDTH`, 10: FIFO address width; width of the `usedw` input.
- `WIN_WIDTH`, 3: window width in elements.
- `WIN_HEIGHT`, 3: window height in elements. N = `WIN_WIDTH*WIN_HEIGHT`. N ≥ 2 and N < 2^`ADDR_WIDTH`.

- `clk_fpga`  in  1  system clock; all logic on its rising edge.
- `reset_fpga`  in  1  synchronous, active-high reset.
- `i_fifo_q`  in  `DATA_WIDTH`  FIFO read data; valid one cycle after `rdreq`.
- `i_fifo_usedw`  in  `ADDR_WIDTH`  FIFO fill level.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_fifo_rdreq`  out  1  FIFO read request; registered.
- `o_window`  out  `DATA_WIDTH*N`  window contents. Element i occupies bits [i*`DATA_WIDTH` +: `DATA_WIDTH`]. Element 0 is the first value read (row-major).
- `o_window_valid`  out  1  window complete and stable.
- `i_window_ready`  in  1  consumer accepts the window.
- `o_underflow`  out  1  sticky error: a read was issued while `i_fifo_empty`=1.

## Operation
- States: IDLE, READ, DRAIN, HOLD.
- **IDLE:**
  - When `i_fifo_usedw` ≥ N, go to READ, set `o_fifo_rdreq`=1, clear the read counter.
  - Otherwise remain in IDLE with `o_fifo_rdreq`=0.
- **READ:**
  - `o_fifo_rdreq` is held high for exactly N consecutive cycles; the read counter counts 0..N-1.
  - After the N-th request cycle, drop `o_fifo_rdreq` and go to DRAIN.
  - The window is never partially requested. `usedw` is not rechecked mid-burst.
- **Capture:** every cycle that follows a cycle with `o_fifo_rdreq`=1 writes `i_fifo_q` into element `cap_idx` and increments `cap_idx` (0..N-1). This holds in READ and DRAIN.
- **DRAIN:** one cycle while the last element is captured. Then assert `o_window_valid` and go to HOLD.
- **HOLD:**
  - `o_window` and `o_window_valid` are held stable.
  - On an edge with `o_window_valid`=1 and `i_window_ready`=1, deassert valid and go to IDLE.
  - A new burst can start no earlier than the cycle after the handshake.
- `o_window` retains the last window after the handshake; it is not cleared.
- `o_underflow`: set when `o_fifo_rdreq`=1 and `i_fifo_empty`=1 on the same edge. It stays set until reset. The burst still completes; the captured value is whatever `i_fifo_q` shows.
- **Reset values:**
  - `o_fifo_rdreq`=0, `o_window_valid`=0, `o_underflow`=0, `o_window`=0.
  - State IDLE; both counters 0.
- **Reset mid-burst:** the partial window is discarded and requests stop on the next cycle. The FIFO is not flushed; any elements already read are lost. The next window starts at element 0.

## Timing
- Cycle numbering for one window: edge k sees `usedw` ≥ N in IDLE.
  - `o_fifo_rdreq`=1 in cycles k+1..k+N.
  - Element i is captured at the end of cycle k+2+i.
  - `o_window_valid`=1 from cycle k+N+2.
- Latency: N+2 cycles from the qualifying `usedw` sample to valid.
- Throughput: a new window at most every N+3 cycles when `i_window_ready` is held at 1.
- `i_window_ready` may be high before valid; this has no effect outside HOLD.
- Counters are `$clog2(N)` bits wide. The compare against `usedw` is zero-extended to `ADDR_WIDTH`.

## Configuration
- `WINDOW_SUM_EN`, defined:
  - Adds output port `o_window_sum`, width `DATA_WIDTH+$clog2(N)`.
  - It is an accumulator cleared on the first capture of each window and adds every captured element.
  - It is final and stable whenever `o_window_valid`=1, and resets to 0.
- `WINDOW_SUM_EN`, undefined: the port and accumulator are absent. All other behaviour is identical.

## Test plan
- Defaults; preload 9 values 1..9, usedw=9; ready=1 → rdreq high exactly 9 cycles; valid 11 cycles after the usedw sample; `o_window` elements 0..8 = 1..9; `o_window_sum`=45 when `WINDOW_SUM_EN` is defined.
- usedw=8 for 20 cycles → rdreq never asserts; valid stays 0. Raise usedw to 9 → burst starts the next cycle.
- Ready held 0 for 30 cycles after valid, with 18 values queued → `o_window` unchanged; no rdreq. Ready=1 → handshake; next burst begins 1 cycle later; second window captured correctly.
- `reset_fpga` pulsed during the 5th rdreq cycle → rdreq 0 the next cycle; valid 0; `o_window`=0. Refill 9 values → clean window with element 0 = first new value.
- Force `i_fifo_empty`=1 during the 3rd rdreq cycle → `o_underflow`=1 from the next cycle; it stays 1 through the handshake and further windows until reset.
- Two windows queued (usedw=18), ready tied 1 → windows delivered 12 cycles apart; contents in order, no element skipped or duplicated.

Source files
------------

// File: rtl/integral_window_deserializer_if.sv
// Bus bundle between the integral-image FIFO, the window deserializer and the classifier.
// o_window_sum exists only when WINDOW_SUM_EN is defined.
interface integral_window_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WIN_WIDTH  = 3,
    parameter int unsigned WIN_HEIGHT = 3
);
    localparam int unsigned N     = WIN_WIDTH * WIN_HEIGHT;
    localparam int unsigned WIN_W = DATA_WIDTH * N;
`ifdef WINDOW_SUM_EN
    localparam int unsigned SUM_W = DATA_WIDTH + $clog2(N);
`endif

    logic [DATA_WIDTH-1:0] i_fifo_q;
    logic [ADDR_WIDTH-1:0] i_fifo_usedw;
    logic                  i_fifo_empty;
    logic                  o_fifo_rdreq;
    logic [WIN_W-1:0]      o_window;
    logic                  o_window_valid;
    logic                  i_window_ready;
    logic                  o_underflow;
`ifdef WINDOW_SUM_EN
    logic [SUM_W-1:0]      o_window_sum;
`endif

    // Deserializer side
    modport master (
        input  i_fifo_q,
        input  i_fifo_usedw,
        input  i_fifo_empty,
        input  i_window_ready,
        output o_fifo_rdreq,
        output o_window,
        output o_window_valid,
        output o_underflow
`ifdef WINDOW_SUM_EN
        ,
        output o_window_sum
`endif
    );

    // FIFO / classifier side
    modport slave (
        output i_fifo_q,
        output i_fifo_usedw,
        output i_fifo_empty,
        output i_window_ready,
        input  o_fifo_rdreq,
        input  o_window,
        input  o_window_valid,
        input  o_underflow
`ifdef WINDOW_SUM_EN
        ,
        input  o_window_sum
`endif
    );
endinterface

// File: rtl/integral_window_deserializer.sv
// Drains one full integral-image window from the FIFO in a single burst and presents it in parallel.
// Optional WINDOW_SUM_EN adds a running sum of the captured window elements.
module integral_window_deserializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WIN_WIDTH  = 3,
    parameter int unsigned WIN_HEIGHT = 3
) (
    input  logic                           clk_fpga,
    input  logic                           reset_fpga,
    integral_window_deserializer_if.master bus
);
    localparam int unsigned N     = WIN_WIDTH * WIN_HEIGHT;
    localparam int unsigned CNT_W = $clog2(N);
    localparam int unsigned WIN_W = DATA_WIDTH * N;
    localparam logic [ADDR_WIDTH-1:0] N_LEVEL  = ADDR_WIDTH'(N);
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(N - 1);
`ifdef WINDOW_SUM_EN
    localparam int unsigned SUM_W = DATA_WIDTH + CNT_W;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] cap_idx;
    logic             rd_pend;
    logic             rdreq;
    logic             window_valid;
    logic             underflow;
    logic [WIN_W-1:0] window;
`ifdef WINDOW_SUM_EN
    logic [SUM_W-1:0] window_sum;
`endif

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            cap_idx      <= '0;
            rd_pend      <= 1'b0;
            rdreq        <= 1'b0;
            window_valid <= 1'b0;
            underflow    <= 1'b0;
            window       <= '0;
`ifdef WINDOW_SUM_EN
            window_sum   <= '0;
`endif
        end else begin
            // FIFO data lags the request by one cycle
            rd_pend <= rdreq;

            if (rdreq && bus.i_fifo_empty) begin
                underflow <= 1'b1;
            end

            if (rd_pend) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (cap_idx == CNT_W'(i)) begin
                        window[i*DATA_WIDTH +: DATA_WIDTH] <= bus.i_fifo_q;
                    end
                end
                cap_idx <= (cap_idx == LAST_IDX) ? '0 : cap_idx + CNT_W'(1);
`ifdef WINDOW_SUM_EN
                // First capture of a window restarts the accumulator
                if (cap_idx == '0) begin
                    window_sum <= SUM_W'(bus.i_fifo_q);
                end else begin
                    window_sum <= window_sum + SUM_W'(bus.i_fifo_q);
                end
`endif
            end

            case (state)
                IDLE: begin
                    if (bus.i_fifo_usedw >= N_LEVEL) begin
                        state  <= READ;
                        rdreq  <= 1'b1;
                        rd_cnt <= '0;
                    end
                end
                READ: begin
                    if (rd_cnt == LAST_IDX) begin
                        rdreq <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    window_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (window_valid && bus.i_window_ready) begin
                        window_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_fifo_rdreq   = rdreq;
    assign bus.o_window       = window;
    assign bus.o_window_valid = window_valid;
    assign bus.o_underflow    = underflow;
`ifdef WINDOW_SUM_EN
    assign bus.o_window_sum   = window_sum;
`endif

endmodule
